sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single 8-bit SDRAM port between two requesters:
  - the data_io ROM/image download stream (ioctl);
  - the CPU-side SRAM-style bus (CE_N/OE_N/WE_N).
- Turns both into single-cycle rd/we strobes with a completion acknowledge.
- Adds a one-entry download write buffer, backpressure, an access timeout and sticky error flags.
- Sits between the download/CPU logic and the sdram controller, in the clk_sys domain.

Parameters:
ADDR_W, 23, address width of all address ports
DATA_W, 8, data width of all data ports
TIMEOUT, 255, max cycles in WAIT before abort (8-bit counter; legal 1..255)

Ports:
clk_sys  in  1  system clock; all logic rising-edge
reset  in  1  synchronous reset, active-high
dl_active  in  1  download in progress (ioctl_download)
dl_wr  in  1  one-cycle download write strobe
dl_addr  in  ADDR_W  download address
dl_data  in  DATA_W  download data
dl_busy  out  1  download buffer full; source must hold off dl_wr
cpu_ce_n  in  1  CPU chip select, active-low
cpu_oe_n  in  1  CPU read strobe, active-low
cpu_we_n  in  1  CPU write strobe, active-low
cpu_addr  in  ADDR_W  CPU address
cpu_din  in  DATA_W  CPU write data
cpu_dout  out  DATA_W  CPU read data
cpu_rdy  out  1  high = CPU access complete / idle
ram_addr  out  ADDR_W  SDRAM address
ram_din  out  DATA_W  SDRAM write data
ram_we  out  1  one-cycle write strobe
ram_rd  out  1  one-cycle read strobe
ram_dout  in  DATA_W  SDRAM read data, valid with ram_ack
ram_ack  in  1  one-cycle completion pulse from controller
overrun_err  out  1  sticky: dl_wr arrived while buffer full
timeout_err  out  1  sticky: WAIT exceeded TIMEOUT

Behaviour:
- Reset values:
  - state = IDLE; dl buffer empty; dl_busy = 0; cpu_rdy = 1; cpu_dout = 0.
  - ram_we = ram_rd = 0; ram_addr = ram_din = 0; both error flags = 0; timeout counter = 0.
- Download buffer:
  - dl_wr with buffer empty → latch dl_addr/dl_data; dl_busy = 1 from the next cycle.
  - Buffer frees the cycle after the ram_ack for its write.
  - dl_wr while full (including the same cycle the buffer frees) → write dropped, overrun_err = 1.
- CPU request:
  - Armed on a rising edge of cpu_req = ~cpu_ce_n & (~cpu_oe_n | ~cpu_we_n), using a registered previous value.
  - Write if cpu_we_n = 0, else read; cpu_addr/cpu_din are latched at the edge.
  - cpu_rdy drops to 0 the cycle after the edge.
  - A held strobe never re-arms.
- States:
  - IDLE: choose a grant.
    - Fixed priority: download buffer over CPU.
    - While dl_active = 1, CPU requests stay pending (cpu_rdy = 0) and are not granted.
  - ISSUE: drive ram_addr/ram_din; pulse ram_we or ram_rd for exactly 1 cycle → WAIT.
  - WAIT: counter increments each cycle.
    - ram_ack → DONE.
    - Counter == TIMEOUT → timeout_err = 1 → DONE with abort.
  - DONE: 1 cycle.
    - CPU read: cpu_dout = ram_dout captured at ram_ack, or 8'hFF on abort.
    - CPU grant: cpu_rdy = 1.
    - Download grant: buffer emptied.
    - Counter cleared → IDLE.
- Latency: CPU edge to cpu_rdy = 1 is 4 cycles + SDRAM latency (edge-detect, IDLE, ISSUE, WAIT…, DONE) when uncontended.
- ram_ack outside WAIT: ignored.
- reset mid-operation: everything returns to reset values next cycle. A pending CPU request is discarded; the CPU must re-strobe.
- Error flags clear only on reset.

Optional Feature:
ARB_ROUND_ROBIN_EN:
- Defined: when both requests are pending in IDLE, grant alternates, with a last-grant bit (reset value: CPU last). The CPU still waits while dl_active = 1 only if no download write is buffered.
- Undefined: fixed download-first priority as above.

Test Plan:
- Reset, then CPU read of 0x000123 with the model returning 8'h5A after 3 cycles → one ram_rd pulse with ram_addr = 0x000123; cpu_dout = 8'h5A; cpu_rdy high 7 cycles after the strobe edge.
- dl_active = 1, dl_wr of 0x000010/8'hC3 → dl_busy = 1 next cycle; ram_we pulse carries 0x000010/8'hC3; dl_busy = 0 the cycle after ram_ack.
- Two dl_wr 1 cycle apart with ram_ack delayed 5 cycles → second write dropped; overrun_err = 1 and stays 1 until reset.
- CPU write and dl_wr in the same cycle (dl_active = 0) → download issued first; CPU write issued after DONE. With ARB_ROUND_ROBIN_EN, repeated contention alternates grants.
- ram_ack never asserted on a CPU read, TIMEOUT = 255 → abort after 255 WAIT cycles; timeout_err = 1; cpu_dout = 8'hFF; cpu_rdy = 1.
- reset asserted during WAIT → the next cycle shows cpu_rdy = 1, dl_busy = 0, no ram strobes; a late ram_ack is ignored.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - SDRAM port arbiter for download and CPU requesters (define ARB_ROUND_ROBIN_EN for alternating grants)
module sdram_port_arbiter #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [DATA_W-1:0] dl_data,
    output logic              dl_busy,
    input  logic              cpu_ce_n,
    input  logic              cpu_oe_n,
    input  logic              cpu_we_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_rdy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_ack,
    output logic              overrun_err,
    output logic              timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [1:0]        state;
    logic              gnt_cpu;
    logic              abort_q;
    logic [7:0]        wait_cnt;
    logic [DATA_W-1:0] rd_q;

    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;

    logic              cpu_req;
    logic              cpu_req_q;
    logic              cpu_edge;
    logic              cpu_pend;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_a;
    logic [DATA_W-1:0] cpu_d;

    logic              wait_ack;
    logic              wait_tmo;
    logic              wait_end;
    logic              cpu_done;
    logic              cpu_arm;
    logic              cpu_elig;
    logic              pick_cpu;
    logic              pick_dl;

    assign cpu_req  = ~cpu_ce_n & (~cpu_oe_n | ~cpu_we_n);
    assign cpu_edge = cpu_req & ~cpu_req_q;
    assign wait_ack = (state == S_WAIT) & ram_ack;
    // Abort on the WAIT cycle whose increment reaches TIMEOUT, so TIMEOUT counts WAIT cycles exactly.
    assign wait_tmo = (state == S_WAIT) & ~ram_ack & ((wait_cnt + 8'd1) == TMO);
    assign wait_end = wait_ack | wait_tmo;
    assign cpu_done = (state == S_DONE) & gnt_cpu;
    // A new edge landing in the completing DONE cycle still arms the next access.
    assign cpu_arm  = cpu_edge & (~cpu_pend | cpu_done);
    assign dl_busy  = buf_full;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_cpu;

    assign cpu_elig = cpu_pend & (~dl_active | buf_full);
    assign pick_cpu = cpu_elig & (~buf_full | ~last_cpu);

    // Remember which side won the last grant so contention alternates.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            last_cpu <= 1'b1;
        end else if ((state == S_IDLE) && (pick_cpu || buf_full)) begin
            last_cpu <= pick_cpu;
        end
    end
`else
    assign cpu_elig = cpu_pend & ~dl_active;
    assign pick_cpu = cpu_elig & ~buf_full;
`endif
    assign pick_dl = buf_full & ~pick_cpu;

    // CPU strobe edge detection and request capture; a held strobe after reset does not re-arm.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cpu_req_q <= cpu_req;
            cpu_pend  <= 1'b0;
            cpu_wr    <= 1'b0;
            cpu_a     <= '0;
            cpu_d     <= '0;
        end else begin
            cpu_req_q <= cpu_req;
            if (cpu_done) begin
                cpu_pend <= 1'b0;
            end
            if (cpu_arm) begin
                cpu_pend <= 1'b1;
                cpu_wr   <= ~cpu_we_n;
                cpu_a    <= cpu_addr;
                cpu_d    <= cpu_din;
            end
        end
    end

    // One-entry download buffer; it frees as its write completes, so a write in that cycle is dropped.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            buf_full    <= 1'b0;
            buf_addr    <= '0;
            buf_data    <= '0;
            overrun_err <= 1'b0;
        end else begin
            if (wait_end && !gnt_cpu) begin
                buf_full <= 1'b0;
            end
            if (dl_wr) begin
                if (buf_full) begin
                    overrun_err <= 1'b1;
                end else begin
                    buf_full <= 1'b1;
                    buf_addr <= dl_addr;
                    buf_data <= dl_data;
                end
            end
        end
    end

    // Access sequencer: grant, single-cycle strobe, wait for ack or timeout, then complete.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= S_IDLE;
            gnt_cpu     <= 1'b0;
            abort_q     <= 1'b0;
            wait_cnt    <= 8'd0;
            rd_q        <= '0;
            ram_addr    <= '0;
            ram_din     <= '0;
            ram_we      <= 1'b0;
            ram_rd      <= 1'b0;
            cpu_dout    <= '0;
            cpu_rdy     <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            ram_rd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_cpu) begin
                        gnt_cpu  <= 1'b1;
                        ram_addr <= cpu_a;
                        ram_din  <= cpu_d;
                        ram_we   <= cpu_wr;
                        ram_rd   <= ~cpu_wr;
                        state    <= S_ISSUE;
                    end else if (pick_dl) begin
                        gnt_cpu  <= 1'b0;
                        ram_addr <= buf_addr;
                        ram_din  <= buf_data;
                        ram_we   <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (wait_ack) begin
                        rd_q    <= ram_dout;
                        abort_q <= 1'b0;
                        state   <= S_DONE;
                    end else if (wait_tmo) begin
                        timeout_err <= 1'b1;
                        abort_q     <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                default: begin
                    wait_cnt <= 8'd0;
                    if (gnt_cpu) begin
                        cpu_rdy <= 1'b1;
                        if (!cpu_wr) begin
                            cpu_dout <= abort_q ? {DATA_W{1'b1}} : rd_q;
                        end
                    end
                    state <= S_IDLE;
                end
            endcase
            if (cpu_arm) begin
                cpu_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

    localparam int TIMEOUT = 255;

    typedef struct packed {
        logic        wr;
        logic        cpu;
        logic [22:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [22:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        dl_busy;
    logic        cpu_ce_n = 1'b1;
    logic        cpu_oe_n = 1'b1;
    logic        cpu_we_n = 1'b1;
    logic [22:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_rdy;
    logic [22:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        ram_rd;
    logic [7:0]  ram_dout = '0;
    logic        ram_ack = 1'b0;
    logic        overrun_err;
    logic        timeout_err;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;
    int   e_cyc = 0;
    int   ack_lat = 3;
    int   late_req = 0;
    txn_t exp_q[$];
    logic [7:0] mem [logic [22:0]];

    // model state: what the outputs must show in the current cycle
    bit         m_full = 1'b0;
    bit         m_over = 1'b0;
    bit         m_tmo = 1'b0;
    bit         m_rdy = 1'b1;
    logic [7:0] m_dout = 8'h00;
    bit         m_pend = 1'b0;
    bit         m_prev = 1'b0;
    bit         o_act = 1'b0;
    bit         o_cpu = 1'b0;
    bit         o_rd = 1'b0;
    int         o_start = 0;
    bit         d_due = 1'b0;
    bit         d_cpu = 1'b0;
    bit         d_rd = 1'b0;
    bit         d_abort = 1'b0;
    logic [7:0] d_data = 8'h00;

    sdram_port_arbiter #(.ADDR_W(23), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_busy(dl_busy),
        .cpu_ce_n(cpu_ce_n), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_rdy(cpu_rdy),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_rd(ram_rd),
        .ram_dout(ram_dout), .ram_ack(ram_ack),
        .overrun_err(overrun_err), .timeout_err(timeout_err)
    );

    initial forever #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by 400000 ns, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic cpu_start(input bit wr, input logic [22:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_din  = d;
        cpu_ce_n = 1'b0;
        cpu_oe_n = wr;
        cpu_we_n = ~wr;
        e_cyc    = cyc;
    endtask

    task automatic cpu_end();
        cpu_ce_n = 1'b1;
        cpu_oe_n = 1'b1;
        cpu_we_n = 1'b1;
    endtask

    task automatic wait_rdy(input int budget, output int dt);
        int n = 0;
        while (!cpu_rdy && n < budget) begin
            step();
            n++;
        end
        if (!cpu_rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cpu_rdy_wait: got cpu_rdy=0 after %0d cycles, want 1", budget);
        end
        dt = cyc - e_cyc;
    endtask

    task automatic push(input bit wr, input bit cpu, input logic [22:0] a, input logic [7:0] d);
        txn_t t;
        t.wr = wr; t.cpu = cpu; t.addr = a; t.data = d;
        exp_q.push_back(t);
    endtask

    // SDRAM controller stand-in: acks ack_lat cycles after each strobe (never when ack_lat is 0)
    initial begin
        int         ack_cnt = 0;
        int         late_seen = 0;
        logic [7:0] rd_val = 8'h00;
        forever begin
            @(posedge clk_sys);
            #1;
            ram_ack = 1'b0;
            if (late_req != late_seen) begin
                ram_ack   = 1'b1;
                late_seen = late_req;
            end
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    ram_ack  = 1'b1;
                    ram_dout = rd_val;
                end
            end
            if (ram_we || ram_rd) begin
                if (ram_we) mem[ram_addr] = ram_din;
                rd_val  = mem.exists(ram_addr) ? mem[ram_addr] : 8'h00;
                ack_cnt = ack_lat;
            end
        end
    end

    // Compare DUT against the model every cycle, then advance the model from this cycle's activity.
    initial begin
        txn_t e;
        bit   req, fin, fin_abort, free_now, acc;
        forever begin
            @(negedge clk_sys);
            if (chk_en) begin
                chk("dl_busy", 32'(dl_busy), 32'(m_full));
                chk("overrun_err", 32'(overrun_err), 32'(m_over));
                chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
                chk("cpu_rdy", 32'(cpu_rdy), 32'(m_rdy));
                chk("cpu_dout", 32'(cpu_dout), 32'(m_dout));
                chk("strobe_excl", 32'(ram_we & ram_rd), 0);
            end
            req = ~cpu_ce_n & (~cpu_oe_n | ~cpu_we_n);
            if (reset) begin
                m_full = 0; m_over = 0; m_tmo = 0; m_rdy = 1; m_dout = 8'h00;
                m_pend = 0; o_act = 0; d_due = 0;
            end else begin
                free_now = 0;
                if (d_due) begin
                    d_due = 0;
                    if (d_cpu) begin
                        m_rdy  = 1;
                        m_pend = 0;
                        if (d_rd) m_dout = d_abort ? 8'hFF : d_data;
                    end
                end
                if (o_act && cyc > o_start) begin
                    fin = 0;
                    fin_abort = 0;
                    if (ram_ack) begin
                        fin = 1;
                        d_data = ram_dout;
                    end else if (cyc - o_start == TIMEOUT) begin
                        fin = 1;
                        fin_abort = 1;
                        m_tmo = 1;
                    end
                    if (fin) begin
                        o_act = 0; d_due = 1; d_cpu = o_cpu; d_rd = o_rd; d_abort = fin_abort;
                        if (!o_cpu) free_now = 1;
                    end
                end
                if (ram_we || ram_rd) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_strobe: got we=%0b rd=%0b addr=0x%0h, want no strobe (cycle %0d)",
                                 ram_we, ram_rd, ram_addr, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe_is_write", 32'(ram_we), 32'(e.wr));
                        chk("ram_addr", 32'(ram_addr), 32'(e.addr));
                        if (e.wr) chk("ram_din", 32'(ram_din), 32'(e.data));
                        o_cpu = e.cpu;
                    end
                    o_act = 1; o_start = cyc; o_rd = ram_rd;
                end
                if (dl_wr && m_full) m_over = 1;
                acc = dl_wr && !m_full;
                if (free_now) m_full = 0;
                if (acc) m_full = 1;
                if (req && !m_prev && !m_pend) begin
                    m_pend = 1;
                    m_rdy  = 0;
                end
            end
            m_prev = req;
        end
    end

    initial begin
        int dt;
        int n;
        mem[23'h000123] = 8'h5A;
        repeat (3) step();
        chk_en = 1'b1;
        reset  = 1'b0;
        chk("rst_cpu_rdy", 32'(cpu_rdy), 1);
        chk("rst_dl_busy", 32'(dl_busy), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_rd", 32'(ram_rd), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_cpu_dout", 32'(cpu_dout), 0);
        chk("rst_errs", 32'({overrun_err, timeout_err}), 0);

        // uncontended CPU read, 3-cycle SDRAM latency
        ack_lat = 3;
        push(0, 1, 23'h000123, 8'h00);
        cpu_start(0, 23'h000123, 8'h00);
        step();
        wait_rdy(50, dt);
        chk("t1_latency", 32'(dt), 7);
        chk("t1_dout", 32'(cpu_dout), 32'h5A);
        cpu_end();
        step();

        // single download write
        dl_active = 1'b1;
        push(1, 0, 23'h000010, 8'hC3);
        dl_addr = 23'h000010; dl_data = 8'hC3; dl_wr = 1'b1;
        step();
        dl_wr = 1'b0;
        chk("t2_busy_set", 32'(dl_busy), 1);
        n = 0;
        while (!ram_ack && n < 50) begin step(); n++; end
        chk("t2_ack_seen", 32'(ram_ack), 1);
        step();
        chk("t2_busy_free", 32'(dl_busy), 0);

        // back-to-back download writes with slow ack: second is dropped
        ack_lat = 5;
        push(1, 0, 23'h000020, 8'h11);
        dl_addr = 23'h000020; dl_data = 8'h11; dl_wr = 1'b1;
        step();
        dl_addr = 23'h000021; dl_data = 8'h22;
        step();
        dl_wr = 1'b0;
        chk("t3_overrun_set", 32'(overrun_err), 1);
        repeat (12) step();
        chk("t3_busy_free", 32'(dl_busy), 0);

        // CPU read held off while download is active
        ack_lat = 2;
        cpu_start(0, 23'h000020, 8'h00);
        repeat (10) step();
        chk("t4_pending_rdy", 32'(cpu_rdy), 0);
        push(0, 1, 23'h000020, 8'h00);
        dl_active = 1'b0;
        wait_rdy(50, dt);
        chk("t4_read_back", 32'(cpu_dout), 32'h11);
        cpu_end();
        step();

        // CPU write and download write in the same cycle: download first
        push(1, 0, 23'h000030, 8'h99);
        push(1, 1, 23'h000040, 8'h77);
        dl_addr = 23'h000030; dl_data = 8'h99; dl_wr = 1'b1;
        cpu_start(1, 23'h000040, 8'h77);
        step();
        dl_wr = 1'b0;
        wait_rdy(50, dt);
        chk("t5_contend_latency", 32'(dt), 11);
        cpu_end();
        step();
        push(0, 1, 23'h000040, 8'h00);
        cpu_start(0, 23'h000040, 8'h00);
        step();
        wait_rdy(50, dt);
        chk("t5_latency", 32'(dt), 6);
        chk("t5_read_back", 32'(cpu_dout), 32'h77);
        cpu_end();
        step();

        // no ack: timeout abort
        ack_lat = 0;
        push(0, 1, 23'h000055, 8'h00);
        cpu_start(0, 23'h000055, 8'h00);
        step();
        wait_rdy(1000, dt);
        chk("t6_tmo_latency", 32'(dt), 259);
        chk("t6_tmo_dout", 32'(cpu_dout), 32'hFF);
        chk("t6_tmo_flag", 32'(timeout_err), 1);
        chk("t6_overrun_sticky", 32'(overrun_err), 1);
        cpu_end();
        step();

        // reset during WAIT with the strobe still held, then a stray ack
        push(0, 1, 23'h000066, 8'h00);
        cpu_start(0, 23'h000066, 8'h00);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t7_rdy", 32'(cpu_rdy), 1);
        chk("t7_busy", 32'(dl_busy), 0);
        chk("t7_strobes", 32'({ram_we, ram_rd}), 0);
        chk("t7_errs_clear", 32'({overrun_err, timeout_err}), 0);
        late_req++;
        repeat (6) step();
        chk("t7_rdy_held", 32'(cpu_rdy), 1);
        cpu_end();
        repeat (2) step();

        chk("exp_queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
